// File: rtl/arb_mux_pkg.sv
// -----------------------------------------------------------------------------
// arb_mux_pkg
// Shared definitions for the N:1 arbitrating mux:
//   MODE_RR / MODE_FIXED : values of the top-level 'mode' input.
//   clog2_min1           : index width that never collapses to zero bits.
// -----------------------------------------------------------------------------
package arb_mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // max(1, $clog2(n)), so a channel index always has at least one bit.
  function automatic int clog2_min1(input int n);
    int c;
    c = $clog2(n);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// -----------------------------------------------------------------------------
// rr_priority_select
// Combinational round-robin search. It finds the first set bit of req,
// starting at (ptr+1) mod N and wrapping upward.
//   req         [N]     : per-channel requests
//   ptr         [SEL_W] : last granted channel (search starts just after it)
//   grant_valid         : some channel is requesting
//   grant_idx   [SEL_W] : winning channel index (0 when grant_valid = 0)
// -----------------------------------------------------------------------------
module rr_priority_select
  import arb_mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             grant_valid,
  output logic [SEL_W-1:0] grant_idx
);

  // Duplicating the request vector turns the wrap-around search into a plain
  // priority encode over the window [start, start+N-1].
  logic [2*N-1:0] req_dbl;
  int             start;

  assign req_dbl = {req, req};

  // NOTE: every output gets a default before the search loop. Otherwise the
  // "no request" path would leave them unassigned and infer latches.
  always_comb begin
    start       = (int'(ptr) >= N - 1) ? 0 : int'(ptr) + 1;
    grant_valid = 1'b0;
    grant_idx   = '0;
    // The loop descends, so the last match, the lowest index in the window, wins.
    for (int j = 2*N - 1; j >= 0; j--) begin
      if (req_dbl[j] && (j >= start) && (j < start + N)) begin
        grant_valid = 1'b1;
        grant_idx   = (j >= N) ? SEL_W'(j - N) : SEL_W'(j);
      end
    end
  end

endmodule

// File: rtl/n_to_one_arb_mux.sv
// -----------------------------------------------------------------------------
// n_to_one_arb_mux
// Selects one of N valid/ready channels into a single registered output beat.
// mode = 0 arbitrates round-robin. mode = 1 passes the channel named by sel.
//   clk, reset (async, active-high)
//   in_data  [N*WIDTH] : channel i at [i*WIDTH +: WIDTH]
//   in_valid [N]       : per-channel request
//   in_ready [N]       : per-channel accept (combinational, one-hot or zero)
//   mode, sel [SEL_W]  : arbitration mode / fixed channel index
//   out_data [WIDTH], out_valid, out_ready, out_grant [SEL_W]
// -----------------------------------------------------------------------------
module n_to_one_arb_mux
  import arb_mux_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int WIDTH = 8,
  localparam int SEL_W = clog2_min1(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_grant
);

  logic             load;
  logic             rr_valid;
  logic [SEL_W-1:0] rr_idx;
  logic             fixed_valid;
  logic             win_valid;
  logic [SEL_W-1:0] win_idx;
  logic [WIDTH-1:0] win_data;
  logic [SEL_W-1:0] rr_ptr;

  // The output register can take a beat when it is empty or being drained.
  assign load = ~out_valid | out_ready;

  rr_priority_select #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_rr_sel (
    .req         (in_valid),
    .ptr         (rr_ptr),
    .grant_valid (rr_valid),
    .grant_idx   (rr_idx)
  );

  // Fixed mode: a compare loop means a sel >= N matches no channel and is
  // never granted.
  always_comb begin
    fixed_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) fixed_valid = in_valid[i];
    end
  end

  assign win_valid = (mode == MODE_FIXED) ? fixed_valid : rr_valid;
  assign win_idx   = (mode == MODE_FIXED) ? sel         : rr_idx;

  always_comb begin
    in_ready = '0;
    win_data = '0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == SEL_W'(i)) begin
        in_ready[i] = load & win_valid;
        win_data    = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments. Every flop then
  // samples pre-edge values no matter how the statements are ordered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_grant <= '0;
      rr_ptr    <= SEL_W'(N - 1);
    end else if (load) begin
      if (win_valid) begin
        out_valid <= 1'b1;
        out_data  <= win_data;
        out_grant <= win_idx;
        if (mode == MODE_RR) rr_ptr <= win_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_n_to_one_arb_mux.sv
module tb_n_to_one_arb_mux;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 4-channel instance
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_ready;
  logic           mode, out_valid, out_ready;
  logic [1:0]     sel, out_grant;
  logic [W-1:0]   out_data;

  // 3-channel instance (out-of-range select)
  logic [3*W-1:0] in_data3;
  logic [2:0]     in_valid3, in_ready3;
  logic           mode3, out_valid3, out_ready3;
  logic [1:0]     sel3, out_grant3;
  logic [W-1:0]   out_data3;

  n_to_one_arb_mux #(.N(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_grant(out_grant)
  );

  n_to_one_arb_mux #(.N(3), .WIDTH(W)) dut3 (
    .clk(clk), .reset(reset), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_grant(out_grant3)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (channel-level rules) ----------------
  bit       m_valid;
  int       m_grant;
  int       m_ptr;
  bit [7:0] m_data;

  task automatic model_reset();
    m_valid = 0; m_grant = 0; m_ptr = N - 1; m_data = 0;
  endtask

  // Winner for the current inputs. Returns -1 when nobody wins.
  function automatic int model_winner(input logic [N-1:0] v, input logic md, input logic [1:0] s);
    if (md) return (int'(s) < N && v[s]) ? int'(s) : -1;
    for (int k = 1; k <= N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // One model-checked cycle on the 4-channel DUT. Task starts 1 time unit after a posedge.
  task automatic model_cycle(input logic [N-1:0] v, input logic md, input logic [1:0] s,
                             input logic rdy, input logic [N*W-1:0] d);
    int w;
    bit ld;
    logic [N-1:0] exp_rdy;
    in_valid = v; mode = md; sel = s; out_ready = rdy; in_data = d;
    #2;
    ld = !m_valid || rdy;
    w  = model_winner(v, md, s);
    exp_rdy = '0;
    if (ld && w >= 0) exp_rdy[w] = 1'b1;
    check("rand_in_ready", 32'(in_ready), 32'(exp_rdy));
    check("rand_out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      check("rand_out_data", 32'(out_data), 32'(m_data));
      check("rand_out_grant", 32'(out_grant), 32'(m_grant));
    end
    @(posedge clk);
    if (ld) begin
      if (w >= 0) begin
        m_valid = 1; m_grant = w; m_data = d[w*W +: W];
        if (!md) m_ptr = w;
      end else begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] valid;
    logic       md;
    logic [1:0] s;
    logic       rdy;
    logic [3:0] exp_ready;
    logic       exp_ov;
    logic [1:0] exp_grant;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[15];

  // Drive one vector. Check in_ready before the edge and outputs after it.
  task automatic drive_vec(input vec_t t, input string tag);
    in_valid = t.valid; mode = t.md; sel = t.s; out_ready = t.rdy;
    #2;
    check({tag, "_in_ready"}, 32'(in_ready), 32'(t.exp_ready));
    @(posedge clk); #1;
    check({tag, "_out_valid"}, 32'(out_valid), 32'(t.exp_ov));
    check({tag, "_out_grant"}, 32'(out_grant), 32'(t.exp_grant));
    check({tag, "_out_data"}, 32'(out_data), 32'(t.exp_data));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [N*W-1:0] rd;
    // fairness x8, sparse wrap, fixed mode, return to rr, idle
    tbl[0]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[1]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
    tbl[2]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    tbl[3]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
    tbl[4]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[5]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
    tbl[6]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    tbl[7]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
    tbl[8]  = '{4'b0100, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    tbl[9]  = '{4'b0101, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[10] = '{4'b1111, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    tbl[11] = '{4'b1111, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    tbl[12] = '{4'b1011, 1'b1, 2'd2, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hA2};
    tbl[13] = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
    tbl[14] = '{4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd1, 8'hA1};

    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
    in_data3 = {8'h33, 8'h22, 8'h11};
    in_valid3 = '0; mode3 = 1'b0; sel3 = '0; out_ready3 = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_grant", 32'(out_grant), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) drive_vec(tbl[i], $sformatf("vec%0d", i));

    // Backpressure. rr_ptr is 1 here, so the next grant goes to channel 2.
    drive_vec('{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2}, "bp_fill");
    for (int i = 0; i < 3; i++)
      drive_vec('{4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA2}, $sformatf("bp_hold%0d", i));
    drive_vec('{4'b1111, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3}, "bp_drain_refill");
    drive_vec('{4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd3, 8'hA3}, "bp_empty");

    // Reset asserted while a beat is held.
    drive_vec('{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0}, "mid_fill");
    drive_vec('{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1}, "mid_fill2");
    out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("mid_reset_out_valid", 32'(out_valid), 32'd0);
    check("mid_reset_out_grant", 32'(out_grant), 32'd0);
    check("mid_reset_out_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive_vec('{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0}, "post_reset");

    // Out-of-range select on the 3-channel instance.
    in_valid = '0;
    mode3 = 1'b0; in_valid3 = 3'b111; out_ready3 = 1'b1;
    @(posedge clk); #1;
    check("oor_fill_valid", 32'(out_valid3), 32'd1);
    check("oor_fill_data", 32'(out_data3), 32'h11);
    mode3 = 1'b1; sel3 = 2'd3; out_ready3 = 1'b0;
    #2;
    check("oor_hold_in_ready", 32'(in_ready3), 32'd0);
    @(posedge clk); #1;
    check("oor_hold_valid", 32'(out_valid3), 32'd1);
    out_ready3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check($sformatf("oor_in_ready%0d", i), 32'(in_ready3), 32'd0);
      @(posedge clk); #1;
      check($sformatf("oor_out_valid%0d", i), 32'(out_valid3), 32'd0);
    end
    in_valid3 = '0;

    // Randomized run against the model.
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      rd = {$urandom, $urandom};
      model_cycle(4'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom),
                  ($urandom_range(0, 3) != 0), rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/n_to_one_arb_mux.md
Name: n_to_one_arb_mux

Overview:
- Parametrised successor to the team's gate-level 4:1 mux.
- Selects one of N input channels onto a single registered output, with a valid/ready handshake on every channel.
- Two modes: round-robin arbitration across all requesting channels, or fixed selection by a select bus (classic mux behaviour, now registered).
- Sits between multiple producers and one shared consumer, e.g. a shared ALU or bus port.

Parameters:
- N, 4, number of input channels (N >= 2).
- WIDTH, 8, data width per channel in bits.
- SEL_W, $clog2(N), select and grant-id width (localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel request.
- in_ready  output  N  per-channel accept; combinational, at most one bit high.
- mode  input  1  0 = round-robin, 1 = fixed select.
- sel  input  SEL_W  channel index used when mode = 1.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.
- out_grant  output  SEL_W  index of the channel whose data is in out_data.

Behaviour:
- Reset (asynchronous, active-high): out_valid = 0, out_data = 0, out_grant = 0, rr_ptr = N-1, so channel 0 has highest priority first.
- load = ~out_valid | out_ready. The output register may capture a new beat this cycle.
- Winner selection is combinational:
  - mode = 0: first i with in_valid[i] = 1, searching from (rr_ptr+1) mod N upward with wrap.
  - mode = 1: winner = sel if in_valid[sel] = 1, otherwise none.
  - mode = 1 with sel >= N: none; no channel is ever granted.
- in_ready[w] = load & winner_exists for the winning channel only; all other in_ready bits are 0.
- Transfer on channel w occurs when in_valid[w] & in_ready[w].
- On a transfer, at the next edge: out_data <= channel w data, out_grant <= w, out_valid <= 1, and rr_ptr <= w (mode 0 only; rr_ptr is held in mode 1).
- If load = 1 and there is no winner: out_valid <= 0 at the next edge; out_data and out_grant hold their values.
- If load = 0 (out_valid & ~out_ready): all state holds and in_ready = 0.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat per cycle while out_ready = 1.
- Simultaneous drain and refill in the same cycle is allowed. There are no bubbles.
- A mode or sel change affects only the next winner decision. A beat already held in the output register is never altered.
- Fairness: in mode 0 with all channels continuously valid and out_ready = 1, grants cycle 0,1,...,N-1,0,...
- in_valid may deassert without a transfer; the block does not require inputs to hold their request.
- Reset asserted mid-transfer: the held beat is dropped and the block returns to reset values immediately (asynchronous).

Decomposition:
- Shared package (arb_mux_pkg):
  - localparam MODE_RR = 1'b0, MODE_FIXED = 1'b1.
  - A function clog2_min1 returning max(1, $clog2(N)).
- Sub-module rr_priority_select: purely combinational.
  - Inputs: req[N], ptr[SEL_W].
  - Outputs: grant_valid, grant_idx[SEL_W].
  - Implemented as a double-width request vector with a priority encoder.
  - Instantiated once; fixed mode bypasses it in the top level.

Test Plan:
- Reset: assert reset mid-beat with out_valid = 1 -> out_valid = 0, out_grant = 0, out_data = 0 immediately; first grant after release goes to channel 0 when all channels request.
- Round-robin fairness: N = 4, all in_valid = 1, out_ready = 1, data_i = 8'hA0+i -> out_grant sequence 0,1,2,3,0 and out_data A0,A1,A2,A3,A0; one beat per cycle.
- Backpressure: out_ready = 0 for 3 cycles with out_valid = 1 -> out_data stable and in_ready = 4'b0000; when out_ready returns to 1, the next beat is captured in the same cycle as the drain.
- Fixed mode: mode = 1, sel = 2, in_valid = 4'b1111 -> only in_ready[2] is ever high; with in_valid[2] = 0, out_valid drops to 0 after the current beat drains; rr_ptr is unchanged on return to mode 0.
- Sparse requests with wrap: rr_ptr = 3, in_valid = 4'b0100 -> grant 2; then in_valid = 4'b0101 -> grant 0, which follows 2 in the search order (3, then 0 after wrap).
- Out-of-range select: N = 3, mode = 1, sel = 3 -> no in_ready bit ever asserts and out_valid = 0 once drained.
